gf180mcu_fd_sc_mcu7t5v0__sipo4: RTL and testbench
=================================================

GF180MCU_FD_SC_MCU7T5V0__SIPO4 -- requirements
Module: gf180mcu_fd_sc_mcu7t5v0__sipo4

Interface
REQ-001 SHALL have parameter: MSB_FIRST, 0, 0 = first received bit lands in Q[0]; 1 = first received bit lands in Q[3].
REQ-002 SHALL have port: CLK  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: RN  input  1  reset; asynchronous, active-low.
REQ-004 SHALL have port: D  input  1  serial data bit.
REQ-005 SHALL have port: E  input  1  bit-valid; D is sampled only when E=1.
REQ-006 SHALL have port: CLR  input  1  synchronous clear of partial word, held word and flags.
REQ-007 SHALL have port: ACK  input  1  consumer accepts the held word.
REQ-008 SHALL have port: Q  output  4  parallel word.
REQ-009 SHALL have port: QV  output  1  Q holds an unaccepted complete word.
REQ-010 SHALL have port: OVF  output  1  sticky overflow flag.

Function
REQ-011 SHALL track bit position in a 2-bit counter CNT, states S0..S3, advancing S0->S1->S2->S3->S0 on each edge with E=1 and holding when E=0.
REQ-012 SHALL write D into shift-register bit CNT (MSB_FIRST=0) or bit 3-CNT (MSB_FIRST=1) on each edge with E=1.
REQ-013 SHALL complete a word on the edge sampling E=1 in S3, wrapping CNT to S0 on that edge.
REQ-014 SHALL, on completion with QV=0, load the 4 assembled bits into Q and set QV on that same edge (zero extra latency).
REQ-015 SHALL hold Q and QV stable while QV=1 and ACK=0.
REQ-016 SHALL clear QV on an edge with QV=1 and ACK=1; ACK with QV=0 SHALL be ignored.
REQ-017 SHALL, when completion coincides with QV=1 and ACK=1, load the new word into Q and keep QV=1.
REQ-018 SHALL, when completion coincides with QV=1 and ACK=0, drop the new word, keep Q unchanged and set OVF (see REQ-025).
REQ-019 SHALL give CLR priority over E and ACK: CLR=1 at an edge forces CNT=S0, shift register=0, Q=0, QV=0, OVF=0.
REQ-020 SHALL leave Q unchanged when QV falls; Q is valid only while QV=1.

Reset
REQ-021 SHALL, while RN=0, asynchronously force CNT=S0, shift register=4'b0000, Q=4'b0000, QV=0, OVF=0, independent of CLK.
REQ-022 SHALL discard any partial word when RN is asserted mid-word; the first E=1 edge after release is bit 0 of a new word.
REQ-023 SHALL, after RN deassertion, process E on the first rising edge of CLK.

Configuration
REQ-024 SHALL gate overflow detection by macro GF180MCU_FD_SC_MCU7T5V0__SIPO4_OVF_EN.
REQ-025 SHALL, with the macro defined, set OVF on the REQ-018 condition and hold it until RN or CLR.
REQ-026 SHALL, without the macro, keep the OVF port and tie it to 0, with no OVF register; REQ-018 drop behaviour is unchanged.

Structure
REQ-027 SHALL take the word width constant (4) and the CNT state encoding S0..S3 from the shared package gf180mcu_fd_sc_mcu7t5v0__pkg.
REQ-028 SHALL place the CNT state machine in one sub-module, gf180mcu_fd_sc_mcu7t5v0__sipo4_cnt, outputting CNT and a completion strobe.
REQ-029 SHALL keep the datapath (shift register, Q, QV, OVF) in the top module.

Verification
REQ-030 SHALL cover: MSB_FIRST=0, E=1 with D=1,0,1,1 on 4 edges -> Q=4'b1101 and QV=1 after the 4th edge; ACK=1 for one edge -> QV=0.
REQ-031 SHALL cover: MSB_FIRST=1, same D sequence -> Q=4'b1011; E=0 gaps between bits -> same result, CNT holds during gaps.
REQ-032 SHALL cover: word A=4'b0011 held, ACK=1 on the completion edge of word B=4'b1100 -> Q=4'b1100 and QV stays 1.
REQ-033 SHALL cover: word held, ACK=0, second word completes -> Q unchanged, OVF=1 (macro on) or OVF=0 (macro off); CLR=1 -> QV=0, OVF=0, Q=0.
REQ-034 SHALL cover: RN low after 2 bits, then release and send 1,1,1,1 -> Q=4'b1111; RN toggled between edges -> outputs clear immediately.

Source files
------------

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__pkg.sv
// -----------------------------------------------------------------------------
// gf180mcu_fd_sc_mcu7t5v0__pkg
// Shared constants and types for the 4-bit serial-in / parallel-out block.
//   WORD_W    : parallel word width (4)
//   cnt_e     : bit-position counter states S0..S3
//   bit_index : maps a counter state to the shift-register bit it writes
// -----------------------------------------------------------------------------
package gf180mcu_fd_sc_mcu7t5v0__pkg;

   localparam int unsigned WORD_W = 4;

   typedef enum logic [1:0] {
      S0 = 2'd0,
      S1 = 2'd1,
      S2 = 2'd2,
      S3 = 2'd3
   } cnt_e;

   // LSB-first: bit N of the word is the Nth received bit.
   // MSB-first: the first received bit lands in the top bit.
   function automatic logic [1:0] bit_index(input cnt_e cnt, input logic msb_first);
      logic [1:0] pos;
      pos = cnt;
      return msb_first ? (2'd3 - pos) : pos;
   endfunction

endpackage

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__sipo4_if.sv
// -----------------------------------------------------------------------------
// gf180mcu_fd_sc_mcu7t5v0__sipo4_if
// Bundles the serial input, control and parallel output signals of the SIPO.
//   D   : serial data bit           E   : bit-valid (D sampled when 1)
//   CLR : synchronous clear         ACK : consumer accepts held word
//   Q   : parallel word             QV  : Q holds an unaccepted word
//   OVF : sticky overflow flag
// Modports: master = producer/consumer side, slave = the SIPO itself.
// -----------------------------------------------------------------------------
interface gf180mcu_fd_sc_mcu7t5v0__sipo4_if;
   import gf180mcu_fd_sc_mcu7t5v0__pkg::*;

   logic              D;
   logic              E;
   logic              CLR;
   logic              ACK;
   logic [WORD_W-1:0] Q;
   logic              QV;
   logic              OVF;

   modport master (output D, E, CLR, ACK, input Q, QV, OVF);
   modport slave  (input D, E, CLR, ACK, output Q, QV, OVF);

endinterface

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__sipo4_cnt.sv
// -----------------------------------------------------------------------------
// gf180mcu_fd_sc_mcu7t5v0__sipo4_cnt
// Bit-position counter for the SIPO. Advances S0->S1->S2->S3->S0 on each
// accepted bit, holds otherwise, and strobes done on the edge that accepts
// the fourth bit of a word.
//   clk  : clock, rising edge        rn   : async active-low reset
//   e    : bit-valid                 clr  : synchronous clear (wins over e)
//   cnt  : current bit position      done : word completes on this edge
// -----------------------------------------------------------------------------
module gf180mcu_fd_sc_mcu7t5v0__sipo4_cnt
   import gf180mcu_fd_sc_mcu7t5v0__pkg::*;
(
   input  logic clk,
   input  logic rn,
   input  logic e,
   input  logic clr,
   output cnt_e cnt,
   output logic done
);

   cnt_e cnt_nxt;

   // NOTE: state registers use non-blocking assignments so every flop samples
   // pre-edge values; the reset branch is asynchronous via the sensitivity list.
   always_ff @(posedge clk or negedge rn) begin
      if (!rn) cnt <= S0;
      else     cnt <= cnt_nxt;
   end

   // NOTE: every output of this block is defaulted first so no path leaves a
   // variable unassigned, which would otherwise infer a latch.
   always_comb begin
      cnt_nxt = cnt;
      done    = 1'b0;
      if (clr) begin
         cnt_nxt = S0;
      end else if (e) begin
         unique case (cnt)
            S0: cnt_nxt = S1;
            S1: cnt_nxt = S2;
            S2: cnt_nxt = S3;
            S3: begin
               cnt_nxt = S0;
               done    = 1'b1;
            end
         endcase
      end
   end

endmodule

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__sipo4.sv
// -----------------------------------------------------------------------------
// gf180mcu_fd_sc_mcu7t5v0__sipo4
// 4-bit serial-in / parallel-out register with a one-word holding stage.
// Bits are accepted while E=1; the fourth bit completes a word which is
// presented on Q with QV=1 on that same edge. The held word stays until ACK.
// A word completing while an unacknowledged word is held is dropped.
//   Parameter MSB_FIRST : 0 = first bit -> Q[0], 1 = first bit -> Q[3]
//   CLK : clock          RN  : async active-low reset
//   bus : slave modport of gf180mcu_fd_sc_mcu7t5v0__sipo4_if (D, E, CLR, ACK,
//         Q, QV, OVF)
// Build option: define GF180MCU_FD_SC_MCU7T5V0__SIPO4_OVF_EN to make OVF a
// sticky flag for dropped words; otherwise OVF is tied to 0.
// -----------------------------------------------------------------------------
module gf180mcu_fd_sc_mcu7t5v0__sipo4
   import gf180mcu_fd_sc_mcu7t5v0__pkg::*;
#(
   parameter bit MSB_FIRST = 1'b0
) (
   input logic                          CLK,
   input logic                          RN,
   gf180mcu_fd_sc_mcu7t5v0__sipo4_if.slave bus
);

   cnt_e              cnt;
   logic              done;
   logic [1:0]        idx;
   logic [WORD_W-1:0] sr;
   logic [WORD_W-1:0] word;
   logic [WORD_W-1:0] q_r;
   logic              qv_r;
   logic              drop;

   gf180mcu_fd_sc_mcu7t5v0__sipo4_cnt u_cnt (
      .clk  (CLK),
      .rn   (RN),
      .e    (bus.E),
      .clr  (bus.CLR),
      .cnt  (cnt),
      .done (done)
   );

   assign idx = bit_index(cnt, MSB_FIRST);

   // The shift register with the incoming bit already merged in; on the
   // completing edge this is the full word, giving zero-latency load into Q.
   always_comb begin
      word      = sr;
      word[idx] = bus.D;
   end

   // A completed word is lost only when the holding stage is still occupied
   // and not being released on this edge.
   assign drop = done && qv_r && !bus.ACK;

   always_ff @(posedge CLK or negedge RN) begin
      if (!RN) begin
         sr   <= '0;
         q_r  <= '0;
         qv_r <= 1'b0;
      end else if (bus.CLR) begin
         sr   <= '0;
         q_r  <= '0;
         qv_r <= 1'b0;
      end else begin
         if (bus.E) sr <= word;
         if (done && !drop) begin
            q_r  <= word;
            qv_r <= 1'b1;
         end else if (qv_r && bus.ACK) begin
            // Q keeps its last value; it is meaningful only while QV=1.
            qv_r <= 1'b0;
         end
      end
   end

`ifdef GF180MCU_FD_SC_MCU7T5V0__SIPO4_OVF_EN
   logic ovf_r;

   always_ff @(posedge CLK or negedge RN) begin
      if (!RN)          ovf_r <= 1'b0;
      else if (bus.CLR) ovf_r <= 1'b0;
      else if (drop)    ovf_r <= 1'b1;
   end

   assign bus.OVF = ovf_r;
`else
   assign bus.OVF = 1'b0;
`endif

   assign bus.Q  = q_r;
   assign bus.QV = qv_r;

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu7t5v0__sipo4.sv
// -----------------------------------------------------------------------------
// tb_gf180mcu_fd_sc_mcu7t5v0__sipo4
// Drives an LSB-first and an MSB-first instance with identical stimulus.
// A word-level reference model (a queue of received bits) pushes every word
// that should appear on Q into per-instance scoreboards; a monitor pops them
// whenever an instance presents a new word and also compares Q/QV/OVF with
// the model state on every falling edge.
// -----------------------------------------------------------------------------
module tb_gf180mcu_fd_sc_mcu7t5v0__sipo4;

`ifdef GF180MCU_FD_SC_MCU7T5V0__SIPO4_OVF_EN
   localparam bit OVF_ON = 1'b1;
`else
   localparam bit OVF_ON = 1'b0;
`endif

   logic clk = 1'b0;
   logic rn  = 1'b0;
   logic d   = 1'b0;
   logic e   = 1'b0;
   logic clr = 1'b0;
   logic ack = 1'b0;

   always #5 clk = ~clk;

   gf180mcu_fd_sc_mcu7t5v0__sipo4_if bus0 ();
   gf180mcu_fd_sc_mcu7t5v0__sipo4_if bus1 ();

   assign bus0.D = d;   assign bus1.D = d;
   assign bus0.E = e;   assign bus1.E = e;
   assign bus0.CLR = clr; assign bus1.CLR = clr;
   assign bus0.ACK = ack; assign bus1.ACK = ack;

   gf180mcu_fd_sc_mcu7t5v0__sipo4 #(.MSB_FIRST(1'b0)) dut0 (.CLK(clk), .RN(rn), .bus(bus0));
   gf180mcu_fd_sc_mcu7t5v0__sipo4 #(.MSB_FIRST(1'b1)) dut1 (.CLK(clk), .RN(rn), .bus(bus1));

   logic [3:0] q_o  [2];
   logic       qv_o [2];
   logic       ovf_o[2];
   assign q_o[0] = bus0.Q;  assign qv_o[0] = bus0.QV;  assign ovf_o[0] = bus0.OVF;
   assign q_o[1] = bus1.Q;  assign qv_o[1] = bus1.QV;  assign ovf_o[1] = bus1.OVF;

   int n_pass  = 0;
   int n_total = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
   endtask

   // ---------------- reference model ----------------
   bit         bits[$];
   logic [3:0] exp_q[2] = '{4'h0, 4'h0};
   logic       exp_qv   = 1'b0;
   logic       exp_ovf  = 1'b0;
   logic [3:0] sb0[$];
   logic [3:0] sb1[$];

   task automatic model_reset();
      bits.delete();
      exp_q[0] = 4'h0;
      exp_q[1] = 4'h0;
      exp_qv   = 1'b0;
      exp_ovf  = 1'b0;
   endtask

   task automatic model_edge(input logic d_i, input logic e_i, input logic clr_i, input logic ack_i);
      logic [3:0] w_lsb;
      logic [3:0] w_msb;
      bit         complete;
      complete = 1'b0;
      if (clr_i) begin
         model_reset();
      end else begin
         if (e_i) begin
            bits.push_back(d_i);
            if (bits.size() == 4) complete = 1'b1;
         end
         if (complete) begin
            w_lsb = 4'h0;
            w_msb = 4'h0;
            foreach (bits[i]) begin
               w_lsb[i]     = bits[i];
               w_msb[3 - i] = bits[i];
            end
            bits.delete();
            if (!exp_qv || ack_i) begin
               exp_q[0] = w_lsb;
               exp_q[1] = w_msb;
               exp_qv   = 1'b1;
               sb0.push_back(w_lsb);
               sb1.push_back(w_msb);
            end else if (OVF_ON) begin
               exp_ovf = 1'b1;
            end
         end else if (exp_qv && ack_i) begin
            exp_qv = 1'b0;
         end
      end
   endtask

   // ---------------- monitor ----------------
   logic ack_s      = 1'b0;
   logic prev_qv[2] = '{1'b0, 1'b0};

   always @(posedge clk) ack_s = ack;

   always @(negedge clk) begin
      for (int k = 0; k < 2; k++) begin
         check($sformatf("q%0d", k),   q_o[k],   exp_q[k]);
         check($sformatf("qv%0d", k),  qv_o[k],  exp_qv);
         check($sformatf("ovf%0d", k), ovf_o[k], exp_ovf);
         // A new word is presented when QV rises, or when QV stays high
         // across an edge on which the previous word was acknowledged.
         if (qv_o[k] && (!prev_qv[k] || ack_s)) begin
            if ((k == 0 ? sb0.size() : sb1.size()) == 0) begin
               n_total++;
               $display("FAIL word%0d: DUT presented %0h, scoreboard empty (t=%0t)", k, q_o[k], $time);
            end else if (k == 0) begin
               check("word0", q_o[0], sb0.pop_front());
            end else begin
               check("word1", q_o[1], sb1.pop_front());
            end
         end
         prev_qv[k] = qv_o[k];
      end
   end

   // ---------------- stimulus ----------------
   task automatic step(input logic d_i, input logic e_i, input logic clr_i, input logic ack_i);
      d   = d_i;
      e   = e_i;
      clr = clr_i;
      ack = ack_i;
      @(posedge clk);
      model_edge(d_i, e_i, clr_i, ack_i);
      @(negedge clk);
   endtask

   task automatic send_word(input logic [3:0] bits_i, input logic ack_last);
      for (int i = 0; i < 4; i++) step(bits_i[i], 1'b1, 1'b0, (i == 3) ? ack_last : 1'b0);
   endtask

   // Assert RN between clock edges and confirm outputs clear without a clock.
   task automatic pulse_reset();
      #1 rn = 1'b0;
      #1;
      for (int k = 0; k < 2; k++) begin
         check($sformatf("async_rst_q%0d", k),   q_o[k],   4'h0);
         check($sformatf("async_rst_qv%0d", k),  qv_o[k],  1'b0);
         check($sformatf("async_rst_ovf%0d", k), ovf_o[k], 1'b0);
      end
      model_reset();
      #1 rn = 1'b1;
   endtask

   initial begin
      repeat (3) @(negedge clk);
      check("rst_q0", q_o[0], 4'h0);
      check("rst_qv0", qv_o[0], 1'b0);
      check("rst_ovf0", ovf_o[0], 1'b0);
      #1 rn = 1'b1;

      // D sequence 1,0,1,1 (first bit sent first): LSB-first 1101, MSB-first 1011.
      send_word(4'b1101, 1'b0);
      check("seq_lsb", q_o[0], 4'b1101);
      check("seq_msb", q_o[1], 4'b1011);
      check("seq_qv", qv_o[0], 1'b1);
      step(1'b0, 1'b0, 1'b0, 1'b1);
      check("ack_clears_qv", qv_o[1], 1'b0);
      check("q_kept_after_ack", q_o[1], 4'b1011);
      step(1'b0, 1'b0, 1'b0, 1'b1);   // ACK with QV=0 is ignored

      // Same sequence with E=0 gaps: counter must hold during gaps.
      step(1'b1, 1'b1, 1'b0, 1'b0); step(1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b1, 1'b0, 1'b0); step(1'b1, 1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b0, 1'b0); step(1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b0, 1'b0);
      check("gap_msb", q_o[1], 4'b1011);
      step(1'b0, 1'b0, 1'b0, 1'b1);

      // Word A held, ACK on completion edge of word B: B replaces A, QV stays.
      send_word(4'b0011, 1'b0);
      send_word(4'b1100, 1'b1);
      check("ack_on_complete_q", q_o[0], 4'b1100);
      check("ack_on_complete_qv", qv_o[0], 1'b1);
      step(1'b0, 1'b0, 1'b0, 1'b1);

      // Word held without ACK, second word dropped.
      send_word(4'b1001, 1'b0);
      send_word(4'b0110, 1'b0);
      check("drop_q", q_o[0], 4'b1001);
      check("drop_ovf", ovf_o[0], OVF_ON);
      step(1'b0, 1'b1, 1'b1, 1'b1);   // CLR beats E and ACK
      check("clr_q", q_o[0], 4'h0);
      check("clr_qv", qv_o[0], 1'b0);
      check("clr_ovf", ovf_o[0], 1'b0);

      // Reset mid-word discards the partial word.
      step(1'b0, 1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b1, 1'b0, 1'b0);
      pulse_reset();
      send_word(4'b1111, 1'b0);
      check("post_rst_word", q_o[0], 4'b1111);
      pulse_reset();                  // held word cleared immediately

      // Randomized traffic.
      for (int n = 0; n < 600; n++) begin
         if ($urandom_range(0, 149) == 0) pulse_reset();
         step(1'($urandom), 1'($urandom_range(0, 3) != 0),
              1'($urandom_range(0, 59) == 0), 1'($urandom_range(0, 2) == 0));
      end

      step(1'b0, 1'b0, 1'b0, 1'b0);
      check("sb0_drained", sb0.size(), 0);
      check("sb1_drained", sb1.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
